// File: rtl/sort4_ctrl.sv
// sort4_ctrl -- sequential bubble sort of four 3-bit elements.
//
// A single shared 3-bit comparator steps through adjacent pairs. Pass 0
// compares (0,1),(1,2),(2,3), pass 1 compares (0,1),(1,2), and pass 2
// compares (0,1). A pair swaps only when the left element is strictly
// greater, so equal values keep their original order.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : load data_in and begin a sort (accepted only in IDLE)
//   data_in   : four 3-bit elements, element i at [3i+2:3i]
//   busy      : high while compare cycles are running
//   done      : one-cycle pulse, dout holds the sorted result
//   dout      : {r3,r2,r1,r0}, ascending once sorted
//   swap_cnt  : number of swaps in the current or most recent sort
//
// Build option
//   SORT4_EARLY_EXIT_EN : when defined, a pass that performs no swaps ends
//                         the sort immediately.

module comparator_3bit (
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic       GT,
    output logic       EQ,
    output logic       LT
);
    assign GT = (A > B);
    assign EQ = (A == B);
    assign LT = (A < B);
endmodule

module sort4_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [11:0] dout,
    output logic [2:0]  swap_cnt
);
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] r_q [4];
    logic [2:0] r_d [4];
    logic [1:0] pass_q, pass_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] swap_cnt_q, swap_cnt_d;
    logic       pass_swp_q, pass_swp_d;   // a swap has occurred in this pass
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0] idx_p1;
    logic [1:0] idx_last;
    logic       cmp_gt, cmp_eq, cmp_lt;
    logic       do_swap;

    assign idx_p1   = idx_q + 2'd1;
    assign idx_last = 2'd2 - pass_q;

    comparator_3bit u_cmp (
        .A  (r_q[idx_q]),
        .B  (r_q[idx_p1]),
        .GT (cmp_gt),
        .EQ (cmp_eq),
        .LT (cmp_lt)
    );

    // Swap only on a clean "greater" result. Requiring EQ and LT to be low
    // also guarantees that equal elements are never reordered.
    assign do_swap = cmp_gt & ~(cmp_eq | cmp_lt);

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        pass_d     = pass_q;
        idx_d      = idx_q;
        swap_cnt_d = swap_cnt_q;
        pass_swp_d = pass_swp_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 4; i++) r_d[i] = data_in[3*i +: 3];
                    swap_cnt_d = 3'd0;
                    pass_d     = 2'd0;
                    idx_d      = 2'd0;
                    pass_swp_d = 1'b0;
                    state_d    = CMP;
                end
            end
            CMP: begin
                if (do_swap) begin
                    r_d[idx_q]  = r_q[idx_p1];
                    r_d[idx_p1] = r_q[idx_q];
                    // Six swaps is the most any 4-element sort can need;
                    // saturating keeps the counter from ever wrapping.
                    if (swap_cnt_q < 3'd6) swap_cnt_d = swap_cnt_q + 3'd1;
                    pass_swp_d = 1'b1;
                end
                if (idx_q == idx_last) begin
                    idx_d      = 2'd0;
                    pass_swp_d = 1'b0;
                    if (pass_q == 2'd2) begin
                        pass_d  = 2'd0;
                        state_d = DONE;
                    end
`ifdef SORT4_EARLY_EXIT_EN
                    else if (!(pass_swp_q | do_swap)) begin
                        pass_d  = 2'd0;
                        state_d = DONE;
                    end
`endif
                    else begin
                        pass_d = pass_q + 2'd1;
                    end
                end else begin
                    idx_d = idx_p1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CMP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            r_q        <= '{default: 3'd0};
            pass_q     <= 2'd0;
            idx_q      <= 2'd0;
            swap_cnt_q <= 3'd0;
            pass_swp_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            pass_q     <= pass_d;
            idx_q      <= idx_d;
            swap_cnt_q <= swap_cnt_d;
            pass_swp_q <= pass_swp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign swap_cnt = swap_cnt_q;
    assign dout     = {r_q[3], r_q[2], r_q[1], r_q[0]};
endmodule

// File: tb/tb_sort4_ctrl.sv
// Testbench for sort4_ctrl: directed cases, an exhaustive sweep of all
// 4096 inputs with random ignored start pulses mid-sort, and reset cases,
// all checked against a behavioural sorting model.

module tb_sort4_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] data_in = 12'd0;
    logic        busy;
    logic        done;
    logic [11:0] dout;
    logic [2:0]  swap_cnt;

    int checks = 0;
    int failures = 0;

    sort4_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .swap_cnt (swap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pack4(input int e0, input int e1, input int e2, input int e3);
        logic [11:0] v;
        v = {e3[2:0], e2[2:0], e1[2:0], e0[2:0]};
        return v;
    endfunction

    // Reference: sorted result, inversion count and done-cycle latency.
    // The number of passes that move something equals the largest count
    // of bigger elements sitting to the left of any one element.
    function automatic void model(input logic [11:0] d, output logic [11:0] srt,
                                  output int inv, output int lat);
        int e[4];
        int q[$];
        int maxl, passes, cyc, tmp;
        inv = 0;
        maxl = 0;
        for (int i = 0; i < 4; i++) begin
            e[i] = int'(d[3*i +: 3]);
            q.push_back(e[i]);
        end
        q.sort();
        srt = 12'd0;
        for (int i = 0; i < 4; i++) begin
            tmp = q[i];
            srt[3*i +: 3] = tmp[2:0];
        end
        for (int j = 0; j < 4; j++) begin
            int left = 0;
            for (int i = 0; i < j; i++) if (e[i] > e[j]) left++;
            inv += left;
            if (left > maxl) maxl = left;
        end
`ifdef SORT4_EARLY_EXIT_EN
        passes = (maxl + 1 > 3) ? 3 : maxl + 1;
`else
        passes = 3;
`endif
        cyc = (passes == 1) ? 3 : (passes == 2) ? 5 : 6;
        lat = cyc + 1;
    endfunction

    // Run one sort; noise_cyc in 1..6 injects an ignored start with random data.
    task automatic sort_check(input logic [11:0] d, input int noise_cyc);
        logic [11:0] exp_d;
        int inv, lat, cyc;
        model(d, exp_d, inv, lat);
        @(negedge clk);
        data_in = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            if (cyc == noise_cyc) begin
                start = 1'b1;
                data_in = 12'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, lat);
        chk("dout", dout, exp_d);
        chk("swap_cnt", swap_cnt, inv);
        chk("busy_at_done", busy, 0);
    endtask

    initial begin
        int cyc, ndone, lat;
        logic [11:0] exp_d;
        int inv;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
        chk("rst_swap", swap_cnt, 0);
        rst_n = 1'b1;

        // {7,5,3,1}: reverse order, six swaps
        sort_check(pack4(7, 5, 3, 1), 0);
        chk("rev_dout_const", dout, pack4(1, 3, 5, 7));
        chk("rev_swap_const", swap_cnt, 6);
        @(negedge clk);
        chk("rev_idle_done", done, 0);
        chk("rev_idle_busy", busy, 0);
        chk("rev_idle_stable", dout, pack4(1, 3, 5, 7));

        // {1,2,3,4}: already sorted
        sort_check(pack4(1, 2, 3, 4), 0);
        chk("sorted_dout_const", dout, pack4(1, 2, 3, 4));
        chk("sorted_swap_const", swap_cnt, 0);

        // {3,3,0,3}: duplicates, stable
        sort_check(pack4(3, 3, 0, 3), 0);
        chk("dup_dout_const", dout, pack4(0, 3, 3, 3));
        chk("dup_swap_const", swap_cnt, 2);

        // Start re-pulsed at cycle 3 with zero data is ignored
        @(negedge clk);
        data_in = pack4(7, 5, 3, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            if (cyc == 3) begin
                start = 1'b1;
                data_in = 12'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("ign_latency", cyc, 7);
        chk("ign_dout", dout, pack4(1, 3, 5, 7));
        chk("ign_swap", swap_cnt, 6);

        // Start held high: re-triggers in the first IDLE cycle after DONE
        @(negedge clk);
        data_in = pack4(7, 5, 3, 1);
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_lat1", cyc, 7);
        @(negedge clk);
        cyc++;
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_done", done, 0);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("hold_lat2", cyc, 15);
        chk("hold_dout2", dout, pack4(1, 3, 5, 7));

        // Reset in the middle of a sort
        @(negedge clk);
        @(negedge clk);
        data_in = pack4(6, 4, 2, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_swap", swap_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);
        chk("mid_rst_idle_busy", busy, 0);

        // Exhaustive sweep; every eighth sort gets a random spurious start
        for (int v = 0; v < 4096; v++) begin
            int nz;
            nz = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0;
            sort_check(12'(v), nz);
        end

        // Random back-to-back sorts, model cross-check of final state
        for (int k = 0; k < 50; k++) begin
            logic [11:0] d;
            d = 12'($urandom);
            sort_check(d, int'($urandom_range(0, 6)));
            model(d, exp_d, inv, lat);
            @(negedge clk);
            chk("rand_idle_stable", dout, exp_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk sampled on rising edge, rst_n synchronous active-low.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  request to load and sort data_in; honoured only in IDLE.
REQ-005 data_in  input  12  four 3-bit unsigned elements, element i at bits [3i+2:3i].
REQ-006 busy  output  1  high while comparisons are in progress.
REQ-007 done  output  1  single-cycle pulse; result valid.
REQ-008 dout  output  12  sorted elements, same packing as data_in, ascending (element 0 smallest).
REQ-009 swap_cnt  output  3  number of swaps performed in the current or last sort (max 6).

Function
REQ-010 The block SHALL instantiate exactly one comparator_3bit (ports A, B, GT, EQ, LT) and use it for every element comparison; no other magnitude comparison of data elements is permitted.
REQ-011 FSM states SHALL be IDLE, CMP, DONE; reset state IDLE.
REQ-012 IDLE: on start=1 at edge 0, SHALL capture data_in into r0..r3, clear swap_cnt, set pass=0, idx=0, enter CMP.
REQ-013 CMP: each cycle the comparator SHALL see A=r[idx], B=r[idx+1]; if GT=1, r[idx] and r[idx+1] SHALL swap at the next edge and swap_cnt SHALL increment.
REQ-014 EQ=1 or LT=1 SHALL NOT swap (stable ordering of equal values).
REQ-015 idx SHALL run 0..(2-pass); after idx=2-pass, pass increments and idx returns to 0; after pass 2 completes the FSM enters DONE.
REQ-016 Full sort SHALL take 6 CMP cycles (3+2+1); busy high in cycles 1..6, done high in cycle 7, then IDLE in cycle 8.
REQ-017 dout SHALL equal {r3,r2,r1,r0} at all times; it is valid while done=1 and SHALL stay stable in IDLE until the next accepted start.
REQ-018 start while in CMP or DONE SHALL be ignored; no queuing.
REQ-019 start held high continuously SHALL re-trigger a new sort in the first IDLE cycle after DONE.
REQ-020 swap_cnt SHALL never wrap; 6 is the maximum reachable value.

Reset
REQ-021 rst_n=0 at any edge, including mid-sort, SHALL force IDLE, r0..r3=0, dout=0, swap_cnt=0, busy=0, done=0, pass=0, idx=0.
REQ-022 A sort interrupted by reset SHALL be discarded; no done pulse follows reset release.

Configuration
REQ-023 Macro SORT4_EARLY_EXIT_EN: when defined, a pass completing with zero swaps in that pass SHALL go directly to DONE (done in the cycle after that pass's last compare).
REQ-024 Without SORT4_EARLY_EXIT_EN, every sort SHALL take exactly 6 CMP cycles regardless of data.

Verification
REQ-025 data_in elements {7,5,3,1}, start one cycle -> done at cycle 7, dout elements {1,3,5,7}, swap_cnt=6.
REQ-026 Elements {1,2,3,4} -> dout {1,2,3,4}, swap_cnt=0; done at cycle 7 without macro, cycle 4 with SORT4_EARLY_EXIT_EN.
REQ-027 Elements {3,3,0,3} -> dout {0,3,3,3}, swap_cnt=2, done at cycle 7 in both configurations.
REQ-028 Start {7,5,3,1}, pulse start again at cycle 3, change data_in to {0,0,0,0} -> second start ignored, dout {1,3,5,7} at done.
REQ-029 Start {6,4,2,0}, rst_n=0 at cycle 3 -> next cycle dout=0, swap_cnt=0, busy=0, no done pulse for the following 10 cycles.
REQ-030 Exhaustive 4096 inputs checked against a reference sort and swap count (inversion count), with done latency per REQ-016/REQ-023.
